// File: rtl/semaphore_pkg.sv
// rtl/semaphore_pkg.sv - shared state, direction and lamp encodings for the intersection scheduler
//
// Purpose: common definitions imported by intersection_scheduler and its bench-facing debug port.
//   state_t     : 3-bit state codes (also driven out on state_o)
//   DIR_A/DIR_B : approach selector stored in next_dir
//   LAMP_*      : {green, yellow, red} lamp triples for one approach
package semaphore_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED_A = 3'd0,
    ST_A_GREEN  = 3'd1,
    ST_A_YELLOW = 3'd2,
    ST_ALLRED_B = 3'd3,
    ST_B_GREEN  = 3'd4,
    ST_B_YELLOW = 3'd5,
    ST_WALK     = 3'd6
  } state_t;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - tick prescaler plus saturating tick counter with synchronous clear
//
// Purpose: divides clk into ticks and counts elapsed ticks within the current state.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of prescaler and count (state-entry edge)
//   tick       : high in the last cycle of each tick (prescaler == TICK_DIV-1)
//   count      : completed ticks since the last clear, saturating at SAT
module tick_timer #(
  parameter int TICK_DIV = 2,
  parameter int CNT_W    = 4,
  parameter int SAT      = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  // A one-bit prescaler is kept for TICK_DIV=1; it simply never leaves 0.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SAT);

  logic [PW-1:0] pre;

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      count <= '0;
    end else if (clr) begin
      pre   <= '0;
      count <= '0;
    end else if (tick) begin
      pre <= '0;
      if (count != CNT_SAT) count <= count + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - two-approach intersection controller with shared pedestrian walk
//
// Purpose: sequences approaches A and B through green, yellow and all-red, inserting a walk
// phase after a yellow whenever a pedestrian request is pending.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   car_a, car_b                       : level demand from each approach
//   ped_req                            : pedestrian request, latched into ped_pending
//   a_green/a_yellow/a_red             : approach A lamps
//   b_green/b_yellow/b_red             : approach B lamps
//   walk                               : pedestrian walk lamp
//   ped_ack                            : high for the first cycle of WALK
//   state_o                            : current state code (debug)
module intersection_scheduler
  import semaphore_pkg::*;
#(
  parameter int TICK_DIV    = 25_000_000,
  parameter int GREEN_T     = 14,
  parameter int MIN_GREEN_T = 4,
  parameter int YELLOW_T    = 1,
  parameter int ALLRED_T    = 2,
  parameter int WALK_T      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_a,
  input  logic       car_b,
  input  logic       ped_req,
  output logic       a_green,
  output logic       a_yellow,
  output logic       a_red,
  output logic       b_green,
  output logic       b_yellow,
  output logic       b_red,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  localparam int MAX_T = max4(GREEN_T, WALK_T, ALLRED_T, YELLOW_T);
  localparam int CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] C_GREEN     = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] C_GREEN_M1  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] C_MIN       = CNT_W'(MIN_GREEN_T);
  localparam logic [CNT_W-1:0] C_MIN_M1    = CNT_W'(MIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] C_YELLOW_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_ALLRED_M1 = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] C_WALK_M1   = CNT_W'(WALK_T - 1);

  state_t           state, state_n;
  logic             next_dir, next_dir_n;
  logic             ped_pending;
  logic             ped_ack_q;
  logic             clr, enter_walk;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             allred_done, yellow_done, walk_done;
  logic             min_reached, green_reached;
  logic [2:0]       a_lamp, b_lamp;

  tick_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .SAT      (MAX_T)
  ) u_tick_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick),
    .count (count)
  );

  // "done" fires on the final cycle of a T-tick phase; "reached" also stays true
  // once the count has passed T, which is what lets a green rest and still exit.
  assign allred_done   = tick && (count == C_ALLRED_M1);
  assign yellow_done   = tick && (count == C_YELLOW_M1);
  assign walk_done     = tick && (count == C_WALK_M1);
  assign min_reached   = (count >= C_MIN)   || (tick && (count == C_MIN_M1));
  assign green_reached = (count >= C_GREEN) || (tick && (count == C_GREEN_M1));

  always_comb begin
    state_n    = state;
    next_dir_n = next_dir;
    case (state)
      ST_ALLRED_A: if (allred_done) state_n = ST_A_GREEN;
      ST_ALLRED_B: if (allred_done) state_n = ST_B_GREEN;
      ST_A_GREEN: begin
        if ((min_reached && ped_pending) || (green_reached && (car_b || ped_pending)))
          state_n = ST_A_YELLOW;
      end
      ST_B_GREEN: begin
        if ((min_reached && ped_pending) || (green_reached && (car_a || ped_pending)))
          state_n = ST_B_YELLOW;
      end
      ST_A_YELLOW: begin
        if (yellow_done) begin
          if (ped_pending) begin
            state_n    = ST_WALK;
            next_dir_n = DIR_B;
          end else begin
            state_n = ST_ALLRED_B;
          end
        end
      end
      ST_B_YELLOW: begin
        if (yellow_done) begin
          if (ped_pending) begin
            state_n    = ST_WALK;
            next_dir_n = DIR_A;
          end else begin
            state_n = ST_ALLRED_A;
          end
        end
      end
      ST_WALK: begin
        if (walk_done) state_n = (next_dir == DIR_A) ? ST_ALLRED_A : ST_ALLRED_B;
      end
      default: state_n = ST_ALLRED_A;
    endcase
  end

  assign clr        = (state_n != state);
  assign enter_walk = (state_n == ST_WALK) && (state != ST_WALK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ALLRED_A;
      next_dir    <= DIR_A;
      ped_pending <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      state     <= state_n;
      next_dir  <= next_dir_n;
      ped_ack_q <= enter_walk;
      // Clearing wins over a same-cycle request: that request is served by this walk.
      if (enter_walk)   ped_pending <= 1'b0;
      else if (ped_req) ped_pending <= 1'b1;
    end
  end

  always_comb begin
    a_lamp = LAMP_RED;
    b_lamp = LAMP_RED;
    walk   = 1'b0;
    case (state)
      ST_A_GREEN:  a_lamp = LAMP_GREEN;
      ST_A_YELLOW: a_lamp = LAMP_YELLOW;
      ST_B_GREEN:  b_lamp = LAMP_GREEN;
      ST_B_YELLOW: b_lamp = LAMP_YELLOW;
      ST_WALK:     walk   = 1'b1;
      default: ;
    endcase
  end

  assign {a_green, a_yellow, a_red} = a_lamp;
  assign {b_green, b_yellow, b_red} = b_lamp;
  assign ped_ack = ped_ack_q;
  assign state_o = state;

endmodule
